// File: rtl/warmboot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : warmboot_sequencer
//  Description : Sequences the iCE40 SB_WARMBOOT primitive. Accepts a boot
//                request (external, or internal after a no-host timeout).
//                Waits for the SPI flash bus to stay idle, then detaches USB
//                so the host sees a disconnect. Finally holds a stable image
//                select and fires the BOOT strobe.
//
//  Ports       : clk_48mhz     - single clock, rising edge
//                reset         - synchronous, active-high
//                boot_req      - boot request from the bootloader core
//                image_sel[1:0]- image index, sampled with boot_req
//                usb_activity  - pulse on any valid received USB packet
//                spi_cs_n      - flash chip select (1 = bus idle)
//                usb_detach    - forces USB pads to SE0 / pull-up off
//                wb_s1, wb_s0  - SB_WARMBOOT image select
//                wb_boot       - SB_WARMBOOT BOOT strobe
//                busy          - sequence in progress (not IDLE)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module warmboot_sequencer #(
    parameter int unsigned DRAIN_CYCLES    = 48,
    parameter int unsigned DETACH_CYCLES   = 480000,
    parameter int unsigned SETUP_CYCLES    = 4,
    parameter int unsigned AUTOBOOT_CYCLES = 0,
    parameter logic [1:0]  AUTOBOOT_IMAGE  = 2'b01,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] image_sel,
    input  logic       usb_activity,
    input  logic       spi_cs_n,
    output logic       usb_detach,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DRAIN  = 3'd1;
    localparam logic [2:0] c_ST_DETACH = 3'd2;
    localparam logic [2:0] c_ST_ARM    = 3'd3;
    localparam logic [2:0] c_ST_FIRE   = 3'd4;

    // Zero-length phases are stretched to one cycle so every state is visited.
    localparam logic [CNT_W-1:0] c_DRAIN_LD  = CNT_W'((DRAIN_CYCLES  == 0) ? 1 : DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] c_DETACH_LD = CNT_W'((DETACH_CYCLES == 0) ? 1 : DETACH_CYCLES);
    localparam logic [CNT_W-1:0] c_SETUP_LD  = CNT_W'((SETUP_CYCLES  == 0) ? 1 : SETUP_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic             c_AB_EN     = (AUTOBOOT_CYCLES != 0);
    // Only meaningful when autoboot is enabled; the wrapped value is never used otherwise.
    localparam logic [CNT_W-1:0] c_AB_LAST   = CNT_W'(AUTOBOOT_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ab_cnt;
    logic             r_host_seen;
    logic [1:0]       r_img_q;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_ab_cnt_nxt;
    logic [1:0]       w_img_nxt;
    logic             w_ab_armed;
    logic             w_ab_fire;

    // Autoboot only runs while no host has ever been seen; activity in the
    // firing cycle itself also suppresses it.
    assign w_ab_armed = c_AB_EN && !r_host_seen && !usb_activity;
    assign w_ab_fire  = w_ab_armed && (r_ab_cnt == c_AB_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ab_cnt_nxt = r_ab_cnt;
        w_img_nxt    = r_img_q;
        case (r_state)
            c_ST_IDLE: begin
                // Saturate at the firing value so the counter never wraps.
                if (w_ab_armed && (r_ab_cnt != c_AB_LAST)) begin
                    w_ab_cnt_nxt = r_ab_cnt + c_ONE;
                end
                if (boot_req) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_img_nxt   = image_sel;
                    w_cnt_nxt   = c_DRAIN_LD;
                end else if (w_ab_fire) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_img_nxt   = AUTOBOOT_IMAGE;
                    w_cnt_nxt   = c_DRAIN_LD;
                end
            end
            c_ST_DRAIN: begin
                // Any flash access restarts the idle window from scratch.
                if (!spi_cs_n) begin
                    w_cnt_nxt = c_DRAIN_LD;
                end else if (r_cnt == c_ONE) begin
                    w_state_nxt = c_ST_DETACH;
                    w_cnt_nxt   = c_DETACH_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            c_ST_DETACH: begin
                if (r_cnt == c_ONE) begin
                    w_state_nxt = c_ST_ARM;
                    w_cnt_nxt   = c_SETUP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            c_ST_ARM: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_state_nxt = c_ST_FIRE;
                end
            end
            c_ST_FIRE: begin
                // Terminal: the FPGA reconfigures out from under us.
                w_state_nxt = c_ST_FIRE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // change in the same cycle the state does.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_ab_cnt     <= '0;
            r_host_seen  <= 1'b0;
            r_img_q      <= 2'b00;
            usb_detach   <= 1'b0;
            wb_s1        <= 1'b0;
            wb_s0        <= 1'b0;
            wb_boot      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ab_cnt     <= w_ab_cnt_nxt;
            r_host_seen  <= r_host_seen | usb_activity;
            r_img_q      <= w_img_nxt;
            usb_detach   <= (w_state_nxt == c_ST_DETACH) || (w_state_nxt == c_ST_ARM) ||
                            (w_state_nxt == c_ST_FIRE);
            {wb_s1, wb_s0} <= (w_state_nxt != c_ST_IDLE) ? w_img_nxt : 2'b00;
            wb_boot      <= (w_state_nxt == c_ST_FIRE);
            busy         <= (w_state_nxt != c_ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_warmboot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_warmboot_sequencer
//  Description : Self-checking bench for warmboot_sequencer. Two instances
//                (nominal timing with autoboot, and all-zero timing
//                parameters) share stimulus and are compared every cycle
//                against a timestamp-based reference model, plus directed
//                checks at the cycle numbers the timing rules dictate.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_warmboot_sequencer;

    logic       clk = 1'b0;
    logic       reset, boot_req, usb_activity, spi_cs_n;
    logic [1:0] image_sel;
    logic       a_detach, a_s1, a_s0, a_boot, a_busy;
    logic       b_detach, b_s1, b_s0, b_boot, b_busy;

    always #5 clk = ~clk;

    warmboot_sequencer #(
        .DRAIN_CYCLES(4), .DETACH_CYCLES(8), .SETUP_CYCLES(2),
        .AUTOBOOT_CYCLES(100), .AUTOBOOT_IMAGE(2'b01), .CNT_W(32)
    ) u_dut_a (
        .clk_48mhz(clk), .reset(reset), .boot_req(boot_req), .image_sel(image_sel),
        .usb_activity(usb_activity), .spi_cs_n(spi_cs_n), .usb_detach(a_detach),
        .wb_s1(a_s1), .wb_s0(a_s0), .wb_boot(a_boot), .busy(a_busy)
    );

    warmboot_sequencer #(
        .DRAIN_CYCLES(0), .DETACH_CYCLES(0), .SETUP_CYCLES(0),
        .AUTOBOOT_CYCLES(0), .AUTOBOOT_IMAGE(2'b11), .CNT_W(8)
    ) u_dut_b (
        .clk_48mhz(clk), .reset(reset), .boot_req(boot_req), .image_sel(image_sel),
        .usb_activity(usb_activity), .spi_cs_n(spi_cs_n), .usb_detach(b_detach),
        .wb_s1(b_s1), .wb_s0(b_s0), .wb_boot(b_boot), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit m_valid = 0;

    // Reference model: a sequence is described by its start and by the cycle
    // DETACH begins; later phases follow from fixed durations.
    int         m_D[2], m_T[2], m_S[2], m_AB[2];
    logic [1:0] m_abimg[2];
    bit         m_in_seq[2], m_host[2];
    logic [1:0] m_img[2];
    int         m_run[2], m_det[2], m_t[2];

    // Sampled outputs: {busy, usb_detach, s1, s0, boot}
    logic [4:0] sa, sb;

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic logic [4:0] model_out(input int i);
        if (!m_in_seq[i])                   return 5'b0;
        if (m_det[i] < 0)                   return {2'b10, m_img[i], 1'b0};
        if (cyc < m_det[i] + m_T[i] + m_S[i]) return {2'b11, m_img[i], 1'b0};
        return {2'b11, m_img[i], 1'b1};
    endfunction

    task automatic model_step(input int i);
        if (reset) begin
            m_in_seq[i] = 0; m_host[i] = 0; m_t[i] = 0;
            m_img[i] = 2'b00; m_det[i] = -1; m_run[i] = 0;
        end else begin
            if (!m_in_seq[i]) begin
                if (boot_req) begin
                    m_in_seq[i] = 1; m_img[i] = image_sel; m_run[i] = 0; m_det[i] = -1;
                end else if (m_AB[i] != 0 && !m_host[i] && !usb_activity &&
                             m_t[i] == m_AB[i] - 1) begin
                    m_in_seq[i] = 1; m_img[i] = m_abimg[i]; m_run[i] = 0; m_det[i] = -1;
                end
            end else if (m_det[i] < 0) begin
                if (spi_cs_n) begin
                    m_run[i]++;
                    if (m_run[i] == m_D[i]) m_det[i] = cyc + 1;
                end else begin
                    m_run[i] = 0;
                end
            end
            if (usb_activity) m_host[i] = 1;
            m_t[i]++;
        end
    endtask

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, advance model.
    task automatic step_cycle(input bit r, input bit bq, input logic [1:0] sel,
                              input bit act, input bit cs);
        reset = r; boot_req = bq; image_sel = sel; usb_activity = act; spi_cs_n = cs;
        @(negedge clk);
        sa = {a_busy, a_detach, a_s1, a_s0, a_boot};
        sb = {b_busy, b_detach, b_s1, b_s0, b_boot};
        if (m_valid) begin
            chk("model_a", sa, model_out(0));
            chk("model_b", sb, model_out(1));
        end
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        if (r) m_valid = 1;
        cyc++;
    endtask

    task automatic do_reset();
        step_cycle(1, 0, 2'b00, 0, 1);
        step_cycle(1, 0, 2'b00, 0, 1);
        chk("reset_state_a", {a_busy, a_detach, a_s1, a_s0, a_boot}, 5'b0);
    endtask

    initial begin
        m_D[0] = eff(4); m_T[0] = eff(8); m_S[0] = eff(2); m_AB[0] = 100; m_abimg[0] = 2'b01;
        m_D[1] = eff(0); m_T[1] = eff(0); m_S[1] = eff(0); m_AB[1] = 0;   m_abimg[1] = 2'b11;
        reset = 1; boot_req = 0; image_sel = 0; usb_activity = 0; spi_cs_n = 1;
        #1;

        // Basic sequence, with a second request during DETACH that must be ignored
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step_cycle(0, (i == 10) || (i == 17), (i == 17) ? 2'b11 : 2'b10, 0, 1);
            if (i == 10) chk("basic_busy_pre",   {4'b0, sa[4]}, 5'd0);
            if (i == 11) chk("basic_busy_rise",  sa, 5'b10100);
            if (i == 14) chk("basic_detach_pre", {4'b0, sa[3]}, 5'd0);
            if (i == 15) chk("basic_detach",     {4'b0, sa[3]}, 5'd1);
            if (i == 24) chk("basic_boot_pre",   {4'b0, sa[0]}, 5'd0);
            if (i >= 25) chk("basic_boot_hold",  sa, 5'b11101);
        end

        // Drain restart on flash activity
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step_cycle(0, i == 10, 2'b10, 0, !(i == 12 || i == 13));
            if (i == 17) chk("drain_detach_pre", {4'b0, sa[3]}, 5'd0);
            if (i == 18) chk("drain_detach",     {4'b0, sa[3]}, 5'd1);
            if (i == 27) chk("drain_boot_pre",   {4'b0, sa[0]}, 5'd0);
            if (i == 28) chk("drain_boot",       {4'b0, sa[0]}, 5'd1);
        end

        // Reset in ARM, restart, then reset in FIRE
        do_reset();
        for (int i = 0; i < 52; i++) begin
            step_cycle((i == 23) || (i == 47), (i == 10) || (i == 30), 2'b11, 0, 1);
            if (i == 23) chk("arm_state",       sa, 5'b11110);
            if (i == 24) chk("reset_arm_out",   sa, 5'b0);
            if (i == 45) chk("restart_boot",    sa, 5'b11111);
            if (i == 48) chk("reset_fire_out",  sa, 5'b0);
        end

        // Autoboot after the no-host timeout
        do_reset();
        for (int i = 0; i < 120; i++) begin
            step_cycle(0, 0, 2'b00, 0, 1);
            if (i == 99)  chk("ab_idle_pre",  {4'b0, sa[4]}, 5'd0);
            if (i == 100) chk("ab_drain",     sa, 5'b10010);
            if (i == 113) chk("ab_boot_pre",  {4'b0, sa[0]}, 5'd0);
            if (i == 114) chk("ab_boot",      sa, 5'b11011);
        end

        // Activity in the firing cycle suppresses autoboot
        do_reset();
        for (int i = 0; i < 110; i++) begin
            step_cycle(0, 0, 2'b00, i == 99, 1);
            if (i == 100) chk("ab_act_same_cycle", {4'b0, sa[4]}, 5'd0);
        end

        // External request beats a simultaneous autoboot
        do_reset();
        for (int i = 0; i < 104; i++) begin
            step_cycle(0, i == 99, 2'b10, 0, 1);
            if (i == 100) chk("req_beats_ab", sa, 5'b10100);
        end

        // Host seen: no autoboot, later request still sequences
        do_reset();
        for (int i = 0; i < 1025; i++) begin
            step_cycle(0, i == 1005, 2'b11, i == 50, 1);
            if (i == 1000) chk("host_seen_idle", {4'b0, sa[4]}, 5'd0);
            if (i == 1020) chk("host_seen_boot", sa, 5'b11111);
        end

        // Randomized rounds against the model
        for (int r = 0; r < 30; r++) begin
            int len;
            do_reset();
            len = 40 + int'($urandom_range(90));
            for (int i = 0; i < len; i++) begin
                step_cycle($urandom_range(79) == 0, $urandom_range(7) == 0,
                           2'($urandom), $urandom_range(39) == 0,
                           $urandom_range(3) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/warmboot_sequencer.md
# warmboot_sequencer

Controller that sequences the iCE40 warmboot primitive for the bootloader top level. It accepts a boot request from the bootloader core, or generates one itself after a no-host timeout. It waits for the SPI flash bus to go idle, then detaches USB so the host sees a disconnect. Finally it presents a stable image select and fires the warmboot BOOT strobe. It sits between `tinyfpga_bootloader` (boot/SPI/USB status) and `SB_WARMBOOT` (S1/S0/BOOT), plus the USB pad output-enable path.

## Interface
- `DRAIN_CYCLES`, default 48: consecutive idle-bus cycles required before detach (1 µs at 48 MHz); 0 treated as 1.
- `DETACH_CYCLES`, default 480000: cycles USB is held detached before arming (10 ms); 0 treated as 1.
- `SETUP_CYCLES`, default 4: cycles S1/S0 are held stable before BOOT rises; 0 treated as 1.
- `AUTOBOOT_CYCLES`, default 0: no-host timeout in cycles; 0 disables autoboot.
- `AUTOBOOT_IMAGE`, default 2'b01: image selected on autoboot.
- `CNT_W`, default 32: width of the shared down counter and the autoboot counter.

Ports:
- `clk_48mhz` input 1: single clock, all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `boot_req` input 1: single-cycle (or level) boot request from the bootloader core.
- `image_sel` input 2: image index, sampled with `boot_req`.
- `usb_activity` input 1: pulse on any valid received USB packet.
- `spi_cs_n` input 1: flash chip select as driven by the bootloader core; 1 = bus idle.
- `usb_detach` output 1: 1 forces the USB pads to tristate/SE0 (gates `usb_tx_en`, disables pull-up).
- `wb_s1`, `wb_s0` output 1 each: to `SB_WARMBOOT` S1/S0.
- `wb_boot` output 1: to `SB_WARMBOOT` BOOT.
- `busy` output 1: 1 in any state other than IDLE.

## Operation
- States: IDLE, DRAIN, DETACH, ARM, FIRE. All outputs are registered.
- Reset: state is IDLE, counters are 0, `host_seen`=0, and all outputs are 0.
- `host_seen`: a sticky flag, set by `usb_activity` in any state and cleared only by reset.
- IDLE, autoboot:
  - When `AUTOBOOT_CYCLES`≠0 and `host_seen`=0, the autoboot counter increments each cycle.
  - When it reaches `AUTOBOOT_CYCLES`−1, an internal request fires with `AUTOBOOT_IMAGE`.
  - `usb_activity` on that same cycle wins: no autoboot occurs.
- IDLE, requests:
  - `boot_req`=1 latches `image_sel` into `img_q` and moves to DRAIN, loading the counter with N=max(DRAIN_CYCLES,1).
  - An external `boot_req` has priority over a simultaneous autoboot; its `image_sel` is used.
- DRAIN:
  - If `spi_cs_n`=1 and counter=1: go to DETACH, loading max(DETACH_CYCLES,1).
  - Otherwise, if `spi_cs_n`=1: decrement the counter.
  - If `spi_cs_n`=0: reload max(DRAIN_CYCLES,1). Any flash activity restarts the drain.
- DETACH: decrement the counter; at counter=1 go to ARM, loading max(SETUP_CYCLES,1).
- ARM: decrement the counter; at counter=1 go to FIRE.
- FIRE: terminal state. Stays until reset, because the device reconfigures.
- Output values by state:
  - `usb_detach`=1 in DETACH, ARM and FIRE.
  - `{wb_s1,wb_s0}`=`img_q` in DRAIN through FIRE, and 0 in IDLE.
  - `wb_boot`=1 only in FIRE.
  - `busy`=1 in every state except IDLE.
- `boot_req` and `image_sel` are ignored outside IDLE. `img_q` never changes once it has been captured.
- Reset asserted in any state (including FIRE) returns to IDLE on the next edge, with all outputs 0 and `img_q`=0.

## Timing
- `boot_req` sampled high at edge k (in IDLE) → DRAIN is active, with `busy`=1 and S1/S0 valid, from cycle k+1.
- With `spi_cs_n` held high and D/T/S the effective cycle counts, the state dwell times are:
  - DRAIN: cycles k+1..k+D.
  - DETACH: cycles k+D+1..k+D+T.
  - ARM: cycles k+D+T+1..k+D+T+S.
  - `wb_boot` rises at cycle k+D+T+S+1.
- S1/S0 are stable at least S+T cycles before BOOT rises, satisfying the warmboot setup requirement.
- Autoboot: with no activity and no request, the internal request fires on cycle `AUTOBOOT_CYCLES`−1 after reset release, and DRAIN starts on the following cycle.
- Counters never wrap. The autoboot counter stops once it fires, or once `host_seen` is set.

## Test plan
- Basic sequence:
  - Stimulus: D=4, T=8, S=2, `spi_cs_n`=1, `boot_req` pulse with `image_sel`=2'b10 at cycle 10.
  - Required: `busy` rises at 11, `{s1,s0}`=10 from 11, `usb_detach` rises at 15, `wb_boot` rises at 25 and stays high.
- Drain restart:
  - Stimulus: same parameters, with `spi_cs_n`=0 during cycles 12–13.
  - Required: DRAIN restarts, `usb_detach` rises at 18, `wb_boot` at 28.
- Autoboot:
  - Stimulus: `AUTOBOOT_CYCLES`=100, no USB traffic.
  - Required: DRAIN starts at cycle 100 with `{s1,s0}`=01, and `wb_boot` fires after 100+D+T+S.
- Host seen:
  - Stimulus: `AUTOBOOT_CYCLES`=100, `usb_activity` pulse at cycle 50.
  - Required: no autoboot within 1000 cycles, `busy`=0. A later `boot_req` still sequences normally.
- Request ignored when busy:
  - Stimulus: a second `boot_req` with `image_sel`=11 while in DETACH.
  - Required: `{s1,s0}` unchanged and timing unchanged.
- Reset mid-operation:
  - Stimulus: reset asserted one cycle in ARM, and separately in FIRE.
  - Required: all outputs 0 on the next cycle, state IDLE, and a new request restarts the full sequence.
